// File: rtl/elastic_skid_pkg.sv
// Shared types for the ready-registered elastic stage (skid buffer).
package elastic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } elastic_skid_state_e;

endpackage

// File: rtl/elastic_skid_ctrl.sv
// Skid buffer control: occupancy FSM plus registered ready_o/valid_o and data-reg load strobes.
// Optional full_o output exists only when ELASTIC_SKID_STATS_EN is defined.
module elastic_skid_ctrl
  import elastic_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic valid_i,
  input  logic ready_i,
  output logic ready_o,
  output logic valid_o,
  output logic load_main_o,
  output logic load_skid_o,
  output logic sel_skid_o
`ifdef ELASTIC_SKID_STATS_EN
  ,
  output logic full_o
`endif
);

  elastic_skid_state_e r_state;
  elastic_skid_state_e w_next;
  logic                r_ready;
  logic                r_valid;
  logic                w_in;
  logic                w_out;

  // Handshakes use the registered flags, so ready_i never reaches ready_o combinationally.
  assign w_in  = valid_i & r_ready;
  assign w_out = r_valid & ready_i;

  always_comb begin
    w_next      = r_state;
    load_main_o = 1'b0;
    load_skid_o = 1'b0;
    sel_skid_o  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_next      = BUSY;
          load_main_o = 1'b1;
        end
      end
      BUSY: begin
        if (w_in && w_out) begin
          load_main_o = 1'b1;
        end else if (w_in) begin
          w_next      = FULL;
          load_skid_o = 1'b1;
        end else if (w_out) begin
          w_next      = EMPTY;
        end
      end
      FULL: begin
        if (w_out) begin
          w_next      = BUSY;
          load_main_o = 1'b1;
          sel_skid_o  = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != FULL);
      r_valid <= (w_next != EMPTY);
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;

`ifdef ELASTIC_SKID_STATS_EN
  assign full_o = (r_state == FULL);
`endif

endmodule

// File: rtl/elastic_skid.sv
// Ready-registered elastic stage: depth-2 FIFO cutting the ready path, full throughput.
// Define ELASTIC_SKID_STATS_EN to add the saturating stall_count_o (cycles spent FULL).
module elastic_skid
  import elastic_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int datapath_reset_p = 0
`ifdef ELASTIC_SKID_STATS_EN
  ,
  parameter int count_width_p    = 16
`endif
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
`ifdef ELASTIC_SKID_STATS_EN
  ,
  output logic [count_width_p-1:0] stall_count_o
`endif
);

  logic [width_p-1:0] r_main;
  logic [width_p-1:0] r_skid;
  logic               w_load_main;
  logic               w_load_skid;
  logic               w_sel_skid;
`ifdef ELASTIC_SKID_STATS_EN
  logic               w_full;
`endif

  elastic_skid_ctrl u_ctrl (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .ready_i     (ready_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .load_main_o (w_load_main),
    .load_skid_o (w_load_skid),
    .sel_skid_o  (w_sel_skid)
`ifdef ELASTIC_SKID_STATS_EN
    ,
    .full_o      (w_full)
`endif
  );

  // Data regs load only on strobes gated by ready_o, so X on data_i never lands while stalled.
  if (datapath_reset_p != 0) begin : g_data_rst
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_main <= '0;
        r_skid <= '0;
      end else begin
        if (w_load_main) r_main <= w_sel_skid ? r_skid : data_i;
        if (w_load_skid) r_skid <= data_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (w_load_main) r_main <= w_sel_skid ? r_skid : data_i;
      if (w_load_skid) r_skid <= data_i;
    end
  end

  assign data_o = r_main;

`ifdef ELASTIC_SKID_STATS_EN
  localparam logic [count_width_p-1:0] CountOne = count_width_p'(1);
  logic [count_width_p-1:0] r_stall;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stall <= '0;
    end else if (w_full && (r_stall != '1)) begin
      r_stall <= r_stall + CountOne;
    end
  end

  assign stall_count_o = r_stall;
`endif

endmodule

// File: tb/tb_elastic_skid.sv
// Self-checking bench for elastic_skid: depth-2 FIFO reference model plus directed literal checks.
// Stall-counter checks are compiled in when ELASTIC_SKID_STATS_EN is defined.
module tb_elastic_skid;

  logic       clk     = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] data_i  = '0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
`ifdef ELASTIC_SKID_STATS_EN
  logic [3:0] stall_count_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elastic_skid #(
    .width_p          (8),
    .datapath_reset_p (0)
`ifdef ELASTIC_SKID_STATS_EN
    ,
    .count_width_p    (4)
`endif
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
`ifdef ELASTIC_SKID_STATS_EN
    ,
    .stall_count_o (stall_count_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two beats; ready means "room after this edge".
  logic [7:0] m_q[$];
  logic       m_ready = 1'b0;
  int         m_cnt   = 0;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_q.delete();
      m_ready = 1'b0;
      m_cnt   = 0;
    end else begin
      automatic bit acc = valid_i && m_ready;
      automatic bit pop = (m_q.size() > 0) && ready_i;
      if (m_q.size() == 2 && m_cnt < 15) m_cnt++;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(data_i);
      m_ready = (m_q.size() < 2);
    end
  end

  always @(negedge clk) begin
    chk("model_valid_o", {31'b0, valid_o}, {31'b0, m_q.size() > 0});
    chk("model_ready_o", {31'b0, ready_o}, {31'b0, m_ready});
    if (m_q.size() > 0) chk("model_data_o", {24'b0, data_o}, {24'b0, m_q[0]});
`ifdef ELASTIC_SKID_STATS_EN
    chk("model_stall_count", {28'b0, stall_count_o}, m_cnt);
`endif
  end

  // Drive at a negedge, then advance to the next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(negedge clk);
  endtask

  initial begin
    int unsigned seq = 0;

    // 1: reset held 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
      chk("rst_ready_o", {31'b0, ready_o}, 32'd0);
    end
    reset_i = 1'b0;
    #1 chk("release_ready_o_before_edge", {31'b0, ready_o}, 32'd0);
    @(negedge clk);
    chk("release_ready_o_after_edge", {31'b0, ready_o}, 32'd1);

    // 2: full-throughput stream
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk("stream_data_o", {24'b0, data_o}, i);
      chk("stream_ready_o", {31'b0, ready_o}, 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("stream_drained", {31'b0, valid_o}, 32'd0);

    // 3: fill to FULL then drain
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    chk("full_ready_o", {31'b0, ready_o}, 32'd0);
    chk("full_data_o", {24'b0, data_o}, 32'hA1);
    step(1'b1, 8'hxx, 1'b0);
    chk("full_hold_data_o", {24'b0, data_o}, 32'hA1);
    step(1'b1, 8'hxx, 1'b1);
    chk("drain_second", {24'b0, data_o}, 32'hA2);
    chk("drain_ready_back", {31'b0, ready_o}, 32'd1);
    step(1'b0, 8'hxx, 1'b1);
    chk("drain_empty", {31'b0, valid_o}, 32'd0);

    // 4: random traffic, two throttling mixes
    for (int i = 0; i < 10000; i++) begin
      automatic logic v = ($urandom_range(0, 3) != 0);
      automatic logic r = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      automatic logic [7:0] d = (v && m_ready) ? 8'(seq) : 8'hxx;
      seq++;
      step(v, d, r);
    end
    step(1'b0, 8'hxx, 1'b1);
    step(1'b0, 8'hxx, 1'b1);
    chk("random_drained", {31'b0, valid_o}, 32'd0);

    // 5: asynchronous reset while FULL
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    chk("pre_reset_full", {31'b0, ready_o}, 32'd0);
    #2 reset_i = 1'b1;
    #1 chk("async_rst_valid_o", {31'b0, valid_o}, 32'd0);
    chk("async_rst_ready_o", {31'b0, ready_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) begin
      step(1'b0, 8'hxx, 1'b1);
      chk("post_reset_no_stale", {31'b0, valid_o}, 32'd0);
    end
    chk("post_reset_ready_o", {31'b0, ready_o}, 32'd1);

`ifdef ELASTIC_SKID_STATS_EN
    // 6: saturating stall counter
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    repeat (20) step(1'b0, 8'hxx, 1'b0);
    chk("stall_saturated", {28'b0, stall_count_o}, 32'd15);
    #2 reset_i = 1'b1;
    #1 chk("stall_cleared", {28'b0, stall_count_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    step(1'b0, 8'hxx, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
